// File: rtl/seq_array_div.sv
// Iterative restoring divider, one quotient bit per clock.
// Recovers quotient/remainder of the 4x4 array multiplier's product.
module seq_array_div #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W:0]    r;
  logic [DIVIDEND_W-1:0] q;
  logic [CW-1:0]         cnt;

  logic [DIVISOR_W:0]    t;
  logic [DIVISOR_W:0]    r_nxt;
  logic [DIVIDEND_W-1:0] q_nxt;
  logic                  ge;

  // Partial remainder stays below the divisor, so its low bits plus
  // the next dividend bit always fit in DIVISOR_W+1 bits.
  always_comb begin
    t     = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    ge    = (t >= {1'b0, dvsr});
    r_nxt = ge ? (t - {1'b0, dvsr}) : t;
    q_nxt = {q[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvsr        <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              dvsr  <= divisor;
              r     <= '0;
              q     <= dividend;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_nxt;
            remainder   <= r_nxt[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_div.sv
// Bench for seq_array_div: randomized and directed divisions
// checked against plain integer division.
module tb_seq_array_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [7:0] hq;
  logic [3:0] hr;
  logic       hz;

  seq_array_div #(
    .DIVIDEND_W(8),
    .DIVISOR_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [7:0] dd, input logic [3:0] dv,
                       output logic [7:0] eq, output logic [3:0] er,
                       output logic ez);
    int a, b;
    a = dd;
    b = dv;
    if (b == 0) begin
      eq = 8'hFF;
      er = 4'h0;
      ez = 1'b1;
    end else begin
      eq = 8'(a / b);
      er = 4'(a % b);
      ez = 1'b0;
    end
  endtask

  task automatic run_div(input logic [7:0] dd, input logic [3:0] dv,
                         input string tag);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         bad;
    model(dd, dv, eq, er, ez);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_done: got %b want 0", tag, done);
    end
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    bad = 0;
    if (dv != 0) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== hq ||
            remainder !== hr || div_by_zero !== hz)
          bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s calc_phase: %0d bad cycles, want busy=1 and held results", tag, bad);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: got done=%b busy=%b want done=1 busy=0",
               tag, done, busy);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      failures++;
      $display("FAIL %s %0d/%0d result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
               tag, dd, dv, quotient, remainder, div_by_zero, eq, er, ez);
    end
    hq = eq;
    hr = er;
    hz = ez;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    hq = '0;
    hr = '0;
    hz = 1'b0;
  endtask

  task automatic test_basic;
    run_div(8'd200, 4'd13, "basic");
  endtask

  task automatic test_roundtrip;
    for (int m = 1; m < 16; m++)
      for (int k = 1; k < 16; k++)
        run_div(8'(m * k), 4'(k), "roundtrip");
  endtask

  task automatic test_boundaries;
    run_div(8'd255, 4'd1, "bnd_255_1");
    run_div(8'd0, 4'd7, "bnd_0_7");
    run_div(8'd14, 4'd15, "bnd_14_15");
    run_div(8'd255, 4'd15, "bnd_255_15");
  endtask

  task automatic test_div_zero;
    run_div(8'd99, 4'd0, "div_zero");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_pulse_len: got done=%b busy=%b want 0 0", done, busy);
    end
    run_div(8'd77, 4'd5, "after_zero");
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++)
      run_div(8'($urandom), ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom),
              "random");
  endtask

  task automatic test_back_to_back;
    int bad;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd13;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start    = (i == 2);
      dividend = 8'd37;
      divisor  = 4'd3;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_start_busy: %0d bad cycles want busy=1", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || quotient !== 8'd15 || remainder !== 4'd5) begin
      failures++;
      $display("FAIL mid_start_result: got done=%b q=%0d r=%0d want 1 15 5",
               done, quotient, remainder);
    end
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd15 || remainder !== 4'd5)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_calc: %0d bad cycles want busy=1 with held 15/5", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || quotient !== 8'd14 || remainder !== 4'd2 ||
        div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: got done=%b q=%0d r=%0d z=%b want 1 14 2 0",
               done, quotient, remainder, div_by_zero);
    end
    hq = 8'd14;
    hr = 4'd2;
    hz = 1'b0;
  endtask

  task automatic test_async_reset;
    int bad;
    run_div(8'd200, 4'd13, "pre_abort");
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd13;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    hq = '0;
    hr = '0;
    hz = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d cycles with done/busy set, want 0", bad);
    end
    run_div(8'd50, 4'd6, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_roundtrip();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
